// File: rtl/riscv_dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state type, default geometry/latency and the byte-lane helper.
package riscv_dmem_pkg;

  localparam int DMEM_DEPTH_DEF   = 256;
  localparam int DMEM_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  // Byte-lane enables for a store; the reserved size behaves as a word when
  // it is not trapped as an error.
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001;
      SZ_HALF: be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Request/response bus between a core (master) and the data-memory
// responder (slave). Clock and reset are carried as plain module ports.
interface riscv_dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/riscv_dmem_ram.sv
// Single-port word array with per-byte write enables. Writes land on the
// rising edge; the read port is combinational so the responder can format
// and register the load result on the same edge that performs the access.
// The array is named D_Mem so it can be preloaded hierarchically and is
// never cleared by reset.
module riscv_dmem_ram #(
  parameter int DEPTH = 256
) (
  input  logic                                   clk_i,
  input  logic                                   we_i,
  input  logic [3:0]                             be_i,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr_i,
  input  logic [31:0]                            wdata_i,
  output logic [31:0]                            rdata_o
);

  logic [31:0] D_Mem [DEPTH];

  assign rdata_o = D_Mem[addr_i];

  // Byte-lane write; lanes whose enable is low keep their old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          D_Mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for a RISC-V core: accepts one load/store at a time,
// waits LATENCY cycles, performs the access once on entry to the response
// state and holds the response until the core takes it.
// Optional feature: define DMEM_ERR_EN to fault out-of-range addresses and
// the reserved size (rsp_err=1, rdata 0, no write); otherwise addresses wrap
// modulo DEPTH, the reserved size acts as a word and rsp_err is tied low.
module riscv_dmem_responder
  import riscv_dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEF,
  parameter int LATENCY = DMEM_LATENCY_DEF
) (
  input logic                   clk1,
  input logic                   rst,
  riscv_dmem_responder_if.slave bus
);

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  dmem_state_e state_q;
  logic [3:0]  cnt_q;

  // captured request (data only, not reset)
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // registered outputs
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        go_resp;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_uns;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_err;
  logic [AW-1:0] ram_idx;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [31:0] rsp_next;

  // Extract the addressed byte/half and extend it; word returns unchanged.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    logic [31:0]        r;
    b = signed'(word[7:0]);
    h = signed'(word[15:0]);
    case (size)
      SZ_BYTE: begin
        ext = b;
        r   = uns ? {24'd0, word[7:0]} : ext;
      end
      SZ_HALF: begin
        ext = h;
        r   = uns ? {16'd0, word[15:0]} : ext;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept = bus.req_valid & req_ready_q;

  // Operands come straight from the bus on a zero-latency accept, otherwise
  // from the registers captured at accept time.
  always_comb begin
    op_we    = we_q;
    op_size  = size_q;
    op_uns   = uns_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      op_we    = bus.req_we;
      op_size  = bus.req_size;
      op_uns   = bus.req_unsigned;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end
  end

  // The edge that enters RESP is the single edge on which memory is touched.
  always_comb begin
    go_resp = 1'b0;
    if (state_q == ST_IDLE) begin
      go_resp = accept && (LATENCY == 0);
    end else if (state_q == ST_WAIT) begin
      go_resp = (cnt_q == 4'd0);
    end
  end

  // Fault detection and address reduction into the array.
  always_comb begin
`ifdef DMEM_ERR_EN
    op_err = (op_addr >= 32'(DEPTH)) || (op_size == SZ_RSVD);
`else
    op_err = 1'b0;
`endif
    ram_idx  = AW'(op_addr % 32'(DEPTH));
    ram_be   = size_to_be(op_size);
    ram_we   = go_resp & op_we & ~op_err & ~rst;
    rsp_next = (op_we | op_err) ? 32'd0 : fmt_load(ram_rdata, op_size, op_uns);
  end

  riscv_dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk1),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_idx),
    .wdata_i (op_wdata),
    .rdata_o (ram_rdata)
  );

  // Handshake FSM with registered outputs: IDLE -> (WAIT) -> RESP -> IDLE.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (go_resp) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_next;
              rsp_err_q   <= op_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= LAT4 - 4'd1;
            end
          end
        end
        ST_WAIT: begin
          if (go_resp) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_next;
            rsp_err_q   <= op_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench for riscv_dmem_responder: directed requests push their
// expected response; a negedge monitor pops and compares each handshake.
`timescale 1ns/1ps
module tb_riscv_dmem_responder;
  import riscv_dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_dmem_responder_if bus();

  riscv_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk1 (clk),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int rise_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: latency on rise, stability while stalled, scoreboard on handshake.
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = 32'd0;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (!prev_v) begin
          rise_cnt++;
          chk("latency", 32'(cyc - acc_cyc), 32'(LAT + 1));
        end else if (!prev_r) begin
          chk("hold_rdata", bus.rsp_rdata, prev_d);
        end
        if (bus.rsp_ready) begin
          chk("req_ready_in_handshake", {31'd0, bus.req_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rdata 0x%08h with no request outstanding", bus.rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk({e.nm, "_rdata"}, bus.rsp_rdata, e.rdata);
            chk({e.nm, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
          end
        end
      end
      prev_v = bus.rsp_valid;
      prev_r = bus.rsp_ready;
      prev_d = bus.rsp_rdata;
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee,
                       input string nm, input bit push);
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept: req_ready still 0 after 50 cycles, required 1", nm);
    end
    acc_cyc = cyc;
    if (push) exp_q.push_back('{er, ee, nm});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input string nm);
    issue(we, sz, uns, a, wd, er, ee, nm, 1'b1);
    drain(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    dut.u_ram.D_Mem[200] = 32'd4;
    dut.u_ram.D_Mem[198] = 32'd0;
    dut.u_ram.D_Mem[201] = 32'hAABBCCDD;
    dut.u_ram.D_Mem[44]  = 32'h44440044;
    dut.u_ram.D_Mem[10]  = 32'h00000077;
    dut.u_ram.D_Mem[50]  = 32'h00000000;

    xact(1'b0, SZ_WORD, 1'b0, 32'd200, 32'd0,  32'd4,  1'b0, "lw200");
    xact(1'b1, SZ_WORD, 1'b0, 32'd198, 32'd24, 32'd0,  1'b0, "sw198");
    chk("mem198", dut.u_ram.D_Mem[198], 32'd24);
    xact(1'b0, SZ_WORD, 1'b0, 32'd198, 32'd0,  32'd24, 1'b0, "lw198");

    dut.u_ram.D_Mem[200] = 32'h000000F3;
    xact(1'b0, SZ_BYTE, 1'b0, 32'd200, 32'd0, 32'hFFFFFFF3, 1'b0, "lb200");
    xact(1'b0, SZ_BYTE, 1'b1, 32'd200, 32'd0, 32'h000000F3, 1'b0, "lbu200");
    dut.u_ram.D_Mem[200] = 32'h00008001;
    xact(1'b0, SZ_HALF, 1'b0, 32'd200, 32'd0, 32'hFFFF8001, 1'b0, "lh200");
    xact(1'b0, SZ_HALF, 1'b1, 32'd200, 32'd0, 32'h00008001, 1'b0, "lhu200");

    xact(1'b1, SZ_BYTE, 1'b0, 32'd201, 32'h00000123, 32'd0, 1'b0, "sb201");
    chk("mem201_sb", dut.u_ram.D_Mem[201], 32'hAABBCC23);
    xact(1'b1, SZ_HALF, 1'b0, 32'd201, 32'h00005566, 32'd0, 1'b0, "sh201");
    chk("mem201_sh", dut.u_ram.D_Mem[201], 32'hAABB5566);
    xact(1'b0, SZ_WORD, 1'b0, 32'd201, 32'd0, 32'hAABB5566, 1'b0, "lw201");
    xact(1'b1, SZ_WORD, 1'b0, 32'd201, 32'h11223384, 32'd0, 1'b0, "sw201");
    xact(1'b0, SZ_BYTE, 1'b0, 32'd201, 32'd0, 32'hFFFFFF84, 1'b0, "lb201");

`ifdef DMEM_ERR_EN
    xact(1'b0, SZ_WORD, 1'b0, 32'd300, 32'd0, 32'd0, 1'b1, "lw300");
`else
    xact(1'b0, SZ_WORD, 1'b0, 32'd300, 32'd0, 32'h44440044, 1'b0, "lw300");
`endif

    // Stalled response: outputs hold and a competing request is refused.
    dut.u_ram.D_Mem[200] = 32'h00001234;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    issue(1'b0, SZ_WORD, 1'b0, 32'd200, 32'd0, 32'h00001234, 1'b0, "hold_lw", 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = SZ_WORD;
      bus.req_addr  = 32'd50;
      bus.req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, 32'h00001234);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    drain("hold");
    @(negedge clk);
    chk("ready_after_rsp", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("mem50_untouched", dut.u_ram.D_Mem[50], 32'd0);

    // Reset while waiting: store abandoned, no response.
    rises = rise_cnt;
    issue(1'b1, SZ_WORD, 1'b0, 32'd10, 32'd99, 32'd0, 1'b0, "rst_sw", 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_wait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (5) @(negedge clk);
    chk("rst_wait_no_rsp", 32'(rise_cnt), 32'(rises));
    chk("mem10_unchanged", dut.u_ram.D_Mem[10], 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_responder.md
RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit data-memory words, word-addressed.
REQ-002 SHALL have parameter LATENCY, default 1: wait cycles between request acceptance and response, range 0..15.
REQ-003 SHALL have port clk1  in  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1: core presents a load/store request.
REQ-006 SHALL have port req_ready  out  1: responder can accept a request this cycle.
REQ-007 SHALL have port req_we  in  1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size  in  2: access size; 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  in  1: load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr  in  32: word index into memory.
REQ-011 SHALL have port req_wdata  in  32: store data; byte/half use the low bits.
REQ-012 SHALL have port rsp_valid  out  1: response available.
REQ-013 SHALL have port rsp_ready  in  1: core accepts the response.
REQ-014 SHALL have port rsp_rdata  out  32: load result, or 0 for stores.
REQ-015 SHALL have port rsp_err  out  1: request faulted.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-017 SHALL capture we/size/unsigned/addr/wdata on the accept cycle (req_valid & req_ready), then go to WAIT, or directly to RESP when LATENCY=0.
REQ-018 SHALL, in WAIT, count down LATENCY cycles and enter RESP once the counter expires; accept-to-rsp_valid latency = LATENCY+1 cycles.
REQ-019 SHALL perform the memory read/write exactly once, on the cycle of entry into RESP; no write occurs on a faulted request.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on the next cycle.
REQ-021 SHALL NOT accept a new request in the cycle the response handshake completes; the next accept is earliest one cycle later.
REQ-022 SHALL, on a word store, replace the whole word.
REQ-023 SHALL, on a half store, replace bits[15:0] and preserve bits[31:16].
REQ-024 SHALL, on a byte store, replace bits[7:0] and preserve bits[31:8].
REQ-025 SHALL, on a load, return bits[7:0] for byte or bits[15:0] for half of the addressed word, sign- or zero-extended per req_unsigned; a word load returns the full word.
REQ-026 SHALL return rsp_rdata=0 on every store response.
REQ-027 SHALL ignore req_valid outside IDLE; the core must hold its request until req_ready.

Reset
REQ-028 SHALL, on rst=1, force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 SHALL, on reset in WAIT, abandon the request: no write and no response.
REQ-030 SHALL, on reset in RESP, drop the pending response.
REQ-031 SHALL NOT clear memory contents on reset; contents are preloadable hierarchically by the testbench.

Configuration
REQ-032 SHALL, with DMEM_ERR_EN defined, set rsp_err=1 with rsp_rdata=0 and no write when req_addr >= DEPTH or req_size=11.
REQ-033 SHALL, without DMEM_ERR_EN, wrap req_addr modulo DEPTH, treat size 11 as word, and tie rsp_err to 0.

Structure
REQ-034 SHALL take the size encodings, FSM state typedef and default DEPTH/LATENCY constants from shared package riscv_dmem_pkg.
REQ-035 SHALL place the storage in sub-module riscv_dmem_ram: a single-port synchronous array with byte-lane write enables and a hierarchically visible array named D_Mem.

Verification
REQ-036 SHALL cover: preload D_Mem[200]=4; LW addr 200 -> rsp_rdata=4 exactly LATENCY+1 cycles after accept; SW 24 to 198, then LW 198 -> 24.
REQ-037 SHALL cover: D_Mem[200]=0x000000F3; LB 200 -> 0xFFFFFFF3; LBU 200 -> 0x000000F3; LH with D_Mem[200]=0x00008001 -> 0xFFFF8001.
REQ-038 SHALL cover: D_Mem[201]=0xAABBCCDD; SB wdata 0x123 to 201 -> D_Mem[201]=0xAABBCC23; SH 0x5566 -> 0xAABB5566.
REQ-039 SHALL cover: hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, a second req_valid is not accepted.
REQ-040 SHALL cover: rst asserted in WAIT during SW 99 to 10 -> D_Mem[10] unchanged, rsp_valid never rises, req_ready=1 the next cycle.
REQ-041 SHALL cover: with DMEM_ERR_EN, LW 300 (DEPTH=256) -> rsp_err=1, rsp_rdata=0; without DMEM_ERR_EN, the same request returns D_Mem[44].
